ecc_secded_enc_pipe: RTL and testbench
======================================

# ecc_secded_enc_pipe

Parametrised, pipelined Hamming SEC/DED encoder for the memory-protection write path. It accepts data words over a valid/ready handshake and emits each word with its ECC check byte after a configurable number of register stages. It also supports diagnostic fault injection, in one-shot or sticky mode, for ASIL-B latent-fault testing of the downstream decoder, and keeps a saturating count of encoded words.

## Interface
- DATA_WIDTH, 64: data word width, legal range 8..120.
- PIPE_STAGES, 2: register stages from input accept to output, legal range 1..3.
- COUNT_WIDTH, 32: width of the encoded-word counter.
- ECC_WIDTH (localparam), P+1: P is the smallest integer with 2^P >= DATA_WIDTH+P+1. DATA_WIDTH=64 gives 8; DATA_WIDTH=32 gives 7.
- clk  in  1  single clock; everything is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_WIDTH  data to encode.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_WIDTH  data, possibly corrupted by injection.
- out_ecc  out  ECC_WIDTH  {overall parity, c[P-1:0]}, possibly corrupted.
- out_injected  out  1  this output word carries an injected fault.
- inj_arm  in  1  one-cycle pulse that captures inj_mask and inj_sticky.
- inj_mask  in  DATA_WIDTH+ECC_WIDTH  XOR mask over {ecc, data}; the MSB is ecc[ECC_WIDTH-1].
- inj_sticky  in  1  0 = one-shot, 1 = applies to every word until cleared.
- inj_clear  in  1  disarms injection.
- inj_armed  out  1  injection is pending or active.
- enc_count  out  COUNT_WIDTH  number of accepted words, saturating.

## Operation
**Code definition**
- Codeword positions run from 1 upward.
- Check bit c[j] sits at position 2^j.
- Data bits fill the remaining positions in ascending order: data[0] at position 3, data[1] at 5, data[2] at 6, data[3] at 7, data[4] at 9, and so on.
- c[j] is the XOR of all data bits whose position has bit j set.
- Overall parity is the XOR of all data bits and all c[j], so the full codeword has even parity.

**Pipeline**
- Stage 1 registers data and check bits when a word is accepted; later stages are plain elastic registers.
- A word is accepted when in_valid && in_ready.
- Each stage loads when it is empty or its contents move on in the same cycle.
- in_ready = !rst && (stage 1 empty || stage 1 advances this cycle). This path is combinational from out_ready, which gives full throughput of one word per cycle.
- Output is held stable while out_valid && !out_ready. The block never drops or duplicates a word.

**Fault injection**
- inj_arm loads the mask register and the sticky flag, and sets armed in the next cycle.
- On acceptance while armed, stage 1 stores {ecc, data} ^ mask and sets the word's injected tag.
- One-shot mode: armed clears in the same edge as the injected word is accepted.
- Sticky mode: armed stays set until inj_clear.
- An inj_arm in the same cycle as an acceptance does not affect that word.
- inj_arm while already armed replaces the mask and mode.
- inj_clear and inj_arm in the same cycle: clear wins, and armed = 0.
- An all-zero mask is still treated as an injection: the word is tagged and one-shot mode disarms.

**Counter**
- enc_count increments by one per accepted word and saturates at all-ones.
- Injected words count.

## Timing
- While rst is high, the block does not accept words: in_ready = 0, so a word offered during reset is not accepted.
- Reset values, all in the cycle after rst is sampled high: out_valid 0, out_data 0, out_ecc 0, out_injected 0, inj_armed 0, enc_count 0, mask register 0, all stage valids 0.
- Reset mid-transfer discards every word in flight.
- Latency: a word accepted at edge N appears on out_valid/out_data/out_ecc after edge N+PIPE_STAGES-1, i.e. valid during cycle N+PIPE_STAGES, provided there is no backpressure.
- inj_armed rises the cycle after inj_arm.
- In one-shot mode, inj_armed falls the cycle after the injected word is accepted.
- enc_count updates the cycle after acceptance.

## Test plan
- **Zero word:** DATA_WIDTH=64, in_data=0 -> out_ecc=8'h00, out_injected=0, output after PIPE_STAGES cycles.
- **Fixed vectors:** in_data=64'hFFFF_FFFF_FFFF_FFFF -> out_ecc=8'hFF; in_data=64'h1 -> 8'h83; in_data=64'h8000_0000_0000_0000 -> 8'hC7.
- **Backpressure:** stream 16 random words, hold out_ready low for 5 cycles mid-stream.
  - Required: in_ready drops once all stages are full, output is held stable, order is preserved, no loss, enc_count=16.
  - At the end of the run, every output is checked against the reference model.
- **One-shot injection:** arm with mask bit 0 set, then send 3 words.
  - Only the first output has data[0] inverted and out_injected=1.
  - inj_armed falls after that word is accepted.
- **Sticky injection and clear:** arm with mask bit ECC_WIDTH+DATA_WIDTH-1 set and sticky=1; send 4 words; assert inj_clear; send 2 more.
  - First 4 outputs have parity inverted; last 2 are clean.
  - Second pass: assert inj_clear together with inj_arm -> inj_armed stays 0.
- **Reset and saturation:** assert rst with 2 words in flight -> out_valid=0 next cycle and no stale output after release. Separately, with COUNT_WIDTH=4, send 20 words -> enc_count=4'hF.

Source files
------------

// File: rtl/ecc_secded_enc_pipe_if.sv
// Signal bundle for ecc_secded_enc_pipe: input word stream, encoded output stream,
// fault-injection controls and status.
interface ecc_secded_enc_pipe_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int COUNT_WIDTH = 32
);
   // Hamming check-bit count over the legal DATA_WIDTH range 8..120, plus overall parity.
   localparam int P_BITS    = (DATA_WIDTH <= 11) ? 4 :
                              (DATA_WIDTH <= 26) ? 5 :
                              (DATA_WIDTH <= 57) ? 6 : 7;
   localparam int ECC_WIDTH = P_BITS + 1;

   logic                            in_valid;
   logic                            in_ready;
   logic [DATA_WIDTH-1:0]           in_data;
   logic                            out_valid;
   logic                            out_ready;
   logic [DATA_WIDTH-1:0]           out_data;
   logic [ECC_WIDTH-1:0]            out_ecc;
   logic                            out_injected;
   logic                            inj_arm;
   logic [DATA_WIDTH+ECC_WIDTH-1:0] inj_mask;
   logic                            inj_sticky;
   logic                            inj_clear;
   logic                            inj_armed;
   logic [COUNT_WIDTH-1:0]          enc_count;

   modport master (
      output in_valid, in_data, out_ready, inj_arm, inj_mask, inj_sticky, inj_clear,
      input  in_ready, out_valid, out_data, out_ecc, out_injected, inj_armed, enc_count
   );

   modport slave (
      input  in_valid, in_data, out_ready, inj_arm, inj_mask, inj_sticky, inj_clear,
      output in_ready, out_valid, out_data, out_ecc, out_injected, inj_armed, enc_count
   );
endinterface

// File: rtl/ecc_secded_enc_pipe.sv
// Pipelined Hamming SEC/DED encoder with elastic stages, one-shot/sticky fault
// injection on {ecc, data} and a saturating encoded-word counter.
module ecc_secded_enc_pipe #(
   parameter int DATA_WIDTH  = 64,
   parameter int PIPE_STAGES = 2,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   ecc_secded_enc_pipe_if.slave bus
);
   function automatic int calc_p(input int dw);
      int p;
      p = 0;
      for (int k = 1; k < 16; k++)
         if (p == 0 && (1 << k) >= dw + k + 1) p = k;
      return p;
   endfunction

   localparam int P         = calc_p(DATA_WIDTH);
   localparam int ECC_WIDTH = P + 1;
   localparam int CW_WIDTH  = DATA_WIDTH + ECC_WIDTH;
   localparam int LAST      = PIPE_STAGES - 1;

   typedef logic [P-1:0][DATA_WIDTH-1:0] chk_mask_t;

   // Row j selects the data bits whose codeword position has bit j set.
   function automatic chk_mask_t build_masks();
      chk_mask_t m;
      int        pos;
      m   = '0;
      pos = 2;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         pos++;
         if ((pos & (pos - 1)) == 0) pos++;
         for (int j = 0; j < P; j++) m[j][i] = (((pos >> j) & 1) == 1);
      end
      return m;
   endfunction

   localparam chk_mask_t CHK_MASK = build_masks();

   logic [P-1:0]           chk;
   logic [ECC_WIDTH-1:0]   ecc_calc;
   logic [CW_WIDTH-1:0]    cw_in;
   logic                   accept;
   logic [PIPE_STAGES-1:0] st_valid;
   logic [PIPE_STAGES-1:0] st_load;
   logic [PIPE_STAGES-1:0] st_inj;
   logic [CW_WIDTH-1:0]    st_cw [PIPE_STAGES];
   logic [CW_WIDTH-1:0]    mask_q;
   logic                   sticky_q;
   logic                   armed_q;
   logic [COUNT_WIDTH-1:0] count_q;

   always_comb begin
      chk = '0;
      for (int j = 0; j < P; j++) chk[j] = ^(bus.in_data & CHK_MASK[j]);
      ecc_calc = {^{bus.in_data, chk}, chk};
      cw_in    = {ecc_calc, bus.in_data};
      if (armed_q) cw_in = cw_in ^ mask_q;
   end

   // A stage can load when it or any stage downstream of it has a hole, or the output drains.
   always_comb begin
      st_load = '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
         st_load[s] = bus.out_ready;
         for (int k = s; k < PIPE_STAGES; k++)
            if (!st_valid[k]) st_load[s] = 1'b1;
      end
   end

   // NOTE: in_ready is combinational from out_ready so a full pipe still streams one word per cycle.
   assign bus.in_ready = !rst && st_load[0];
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: stage payloads are reset too, since out_data/out_ecc must read zero after reset.
         st_valid <= '0;
         st_inj   <= '0;
         for (int s = 0; s < PIPE_STAGES; s++) st_cw[s] <= '0;
         mask_q   <= '0;
         sticky_q <= 1'b0;
         armed_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         if (st_load[0]) begin
            st_valid[0] <= accept;
            if (accept) begin
               st_cw[0]  <= cw_in;
               st_inj[0] <= armed_q;
            end
         end
         for (int s = 1; s < PIPE_STAGES; s++) begin
            if (st_load[s]) begin
               st_valid[s] <= st_valid[s-1];
               if (st_valid[s-1]) begin
                  st_cw[s]  <= st_cw[s-1];
                  st_inj[s] <= st_inj[s-1];
               end
            end
         end

         if (bus.inj_arm) begin
            mask_q   <= bus.inj_mask;
            sticky_q <= bus.inj_sticky;
         end
         if (bus.inj_clear)                         armed_q <= 1'b0;
         else if (bus.inj_arm)                      armed_q <= 1'b1;
         else if (accept && armed_q && !sticky_q)   armed_q <= 1'b0;

         if (accept && count_q != '1) count_q <= count_q + COUNT_WIDTH'(1);
      end
   end

   assign bus.out_valid    = st_valid[LAST];
   assign bus.out_data     = st_cw[LAST][DATA_WIDTH-1:0];
   assign bus.out_ecc      = st_cw[LAST][CW_WIDTH-1:DATA_WIDTH];
   assign bus.out_injected = st_inj[LAST];
   assign bus.inj_armed    = armed_q;
   assign bus.enc_count    = count_q;
endmodule

// File: tb/tb_ecc_secded_enc_pipe.sv
// Scoreboard bench for ecc_secded_enc_pipe: stimulus pushes expected words, a monitor
// pops and compares on every output transfer; a second small instance covers saturation.
module tb_ecc_secded_enc_pipe;
   localparam int DW    = 64;
   localparam int EW    = 8;
   localparam int PIPE  = 2;
   localparam int DW2   = 32;
   localparam int PIPE2 = 3;
   localparam int CNT2  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ecc_secded_enc_pipe_if #(.DATA_WIDTH(DW),  .COUNT_WIDTH(32))   bus  ();
   ecc_secded_enc_pipe_if #(.DATA_WIDTH(DW2), .COUNT_WIDTH(CNT2)) bus2 ();

   ecc_secded_enc_pipe #(.DATA_WIDTH(DW), .PIPE_STAGES(PIPE), .COUNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .bus(bus));
   ecc_secded_enc_pipe #(.DATA_WIDTH(DW2), .PIPE_STAGES(PIPE2), .COUNT_WIDTH(CNT2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2));

   typedef struct packed {
      logic          inj;
      logic [EW-1:0] ecc;
      logic [DW-1:0] data;
   } word_t;

   word_t             sb[$];
   int                errors = 0;
   int                checks = 0;
   logic              rst_next = 1'b1;
   logic              or_next  = 1'b1;
   logic              m_armed  = 1'b0;
   logic              m_sticky = 1'b0;
   logic [DW+EW-1:0]  m_mask   = '0;
   logic [31:0]       m_count  = '0;
   logic              held_pending = 1'b0;
   word_t             held;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: lay the data out in codeword positions, then derive each check bit from positions.
   function automatic logic [EW-1:0] model_ecc(input logic [DW-1:0] d);
      logic          cw [1:DW+EW-1];
      logic [EW-2:0] c;
      int            k;
      k = 0;
      for (int pos = 1; pos <= DW + EW - 1; pos++) begin
         if ((pos & (pos - 1)) == 0) cw[pos] = 1'b0;
         else begin
            cw[pos] = d[k];
            k++;
         end
      end
      c = '0;
      for (int j = 0; j < EW - 1; j++)
         for (int pos = 1; pos <= DW + EW - 1; pos++)
            if (((pos >> j) & 1) == 1) c[j] = c[j] ^ cw[pos];
      return {(^d) ^ (^c), c};
   endfunction

   task automatic cycle(input logic v, input logic [DW-1:0] d, input logic arm,
                        input logic [DW+EW-1:0] mask, input logic sticky, input logic clr,
                        output logic acc);
      logic  exp_rdy;
      word_t w;
      @(negedge clk);
      check("inj_armed", 128'(bus.inj_armed), 128'(m_armed));
      check("enc_count", 128'(bus.enc_count), 128'(m_count));
      rst            = rst_next;
      bus.out_ready  = or_next;
      bus.in_valid   = v;
      bus.in_data    = d;
      bus.inj_arm    = arm;
      bus.inj_mask   = mask;
      bus.inj_sticky = sticky;
      bus.inj_clear  = clr;
      #1;
      exp_rdy = !rst && (sb.size() < PIPE || or_next);
      check("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
      acc = v && bus.in_ready;
      if (rst) begin
         sb.delete();
         m_armed  = 1'b0;
         m_sticky = 1'b0;
         m_mask   = '0;
         m_count  = '0;
      end else begin
         if (acc) begin
            w.data = d;
            w.ecc  = model_ecc(d);
            w.inj  = m_armed;
            if (m_armed) {w.ecc, w.data} = {w.ecc, w.data} ^ m_mask;
            sb.push_back(w);
            if (m_count != '1) m_count++;
            if (m_armed && !m_sticky) m_armed = 1'b0;
         end
         if (arm) begin
            m_mask   = mask;
            m_sticky = sticky;
            m_armed  = 1'b1;
         end
         if (clr) m_armed = 1'b0;
      end
   endtask

   task automatic idle();
      logic acc;
      cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, acc);
   endtask

   task automatic ctrl(input logic arm, input logic [DW+EW-1:0] mask, input logic sticky,
                       input logic clr);
      logic acc;
      cycle(1'b0, '0, arm, mask, sticky, clr, acc);
   endtask

   task automatic send(input logic [DW-1:0] d);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
         cycle(1'b1, d, 1'b0, '0, 1'b0, 1'b0, acc);
         tries++;
      end
      if (!acc) check("send_timeout", 128'(acc), 128'(1));
   endtask

   task automatic vec_test(input logic [DW-1:0] d, input logic [EW-1:0] ecc_exp);
      send(d);
      for (int k = 1; k < PIPE; k++) begin
         idle();
         check("latency_early", 128'(bus.out_valid), 128'(0));
      end
      idle();
      check("latency_valid", 128'(bus.out_valid), 128'(1));
      check("vec_ecc", 128'(bus.out_ecc), 128'(ecc_exp));
      check("vec_injected", 128'(bus.out_injected), 128'(0));
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && sb.size() > 0; k++) idle();
      check("drain_empty", 128'(sb.size()), 128'(0));
   endtask

   function automatic logic [DW-1:0] rnd();
      return {$urandom, $urandom};
   endfunction

   // Monitor: compares every output transfer against the scoreboard and checks held words.
   initial begin
      word_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst) held_pending = 1'b0;
         else begin
            if (held_pending) begin
               check("held_stable",
                     128'({bus.out_valid, bus.out_injected, bus.out_ecc, bus.out_data}),
                     128'({1'b1, held}));
               held_pending = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) check("output_without_word", 128'(bus.out_valid), 128'(0));
               else begin
                  e = sb.pop_front();
                  check("out_word", 128'({bus.out_injected, bus.out_ecc, bus.out_data}), 128'(e));
               end
            end else if (bus.out_valid) begin
               held_pending = 1'b1;
               held         = {bus.out_injected, bus.out_ecc, bus.out_data};
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic             acc;
      logic [DW-1:0]    r;
      logic [DW+EW-1:0] mask;
      int               n;
      int               n2;
      bit               seen;

      bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b1;
      bus.inj_arm  = 1'b0;  bus.inj_mask = '0; bus.inj_sticky = 1'b0; bus.inj_clear = 1'b0;
      bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b1;
      bus2.inj_arm  = 1'b0; bus2.inj_mask = '0; bus2.inj_sticky = 1'b0; bus2.inj_clear = 1'b0;

      rst_next = 1'b1;
      repeat (3) idle();
      check("reset_out_valid", 128'(bus.out_valid), 128'(0));
      check("reset_out_data", 128'({bus.out_injected, bus.out_ecc, bus.out_data}), 128'(0));
      rst_next = 1'b0;
      idle();

      vec_test(64'h0, 8'h00);
      vec_test(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      vec_test(64'h1, 8'h83);
      vec_test(64'h8000_0000_0000_0000, 8'hC7);

      // Backpressure stream of 16 words with a 5-cycle stall.
      rst_next = 1'b1; idle(); rst_next = 1'b0; idle();
      n = 0;
      r = rnd();
      for (int cyc = 0; cyc < 200 && n < 16; cyc++) begin
         or_next = !(cyc >= 6 && cyc < 11);
         cycle(1'b1, r, 1'b0, '0, 1'b0, 1'b0, acc);
         if (cyc == 10) check("bp_in_ready_low", 128'(bus.in_ready), 128'(0));
         if (acc) begin
            n++;
            r = rnd();
         end
      end
      check("bp_words_sent", 128'(n), 128'(16));
      or_next = 1'b1;
      drain();
      check("bp_enc_count", 128'(bus.enc_count), 128'(16));

      // One-shot: arm in the same cycle as an accept (that word stays clean), then 3 words.
      cycle(1'b1, rnd(), 1'b1, 72'(1), 1'b0, 1'b0, acc);
      check("arm_with_accept", 128'(acc), 128'(1));
      repeat (3) send(rnd());
      drain();
      check("oneshot_disarmed", 128'(bus.inj_armed), 128'(0));

      // All-zero mask still tags and disarms.
      ctrl(1'b1, '0, 1'b0, 1'b0);
      repeat (2) send(rnd());
      drain();

      // Sticky parity flip, then clear.
      mask = 72'(1) << (DW + EW - 1);
      ctrl(1'b1, mask, 1'b1, 1'b0);
      repeat (4) send(rnd());
      ctrl(1'b0, '0, 1'b0, 1'b1);
      repeat (2) send(rnd());
      drain();

      // Clear and arm together: clear wins.
      ctrl(1'b1, mask, 1'b1, 1'b1);
      idle();
      check("clear_beats_arm", 128'(bus.inj_armed), 128'(0));
      send(rnd());
      drain();

      // Re-arm while armed replaces mask and mode.
      ctrl(1'b1, 72'(1) << 5, 1'b1, 1'b0);
      ctrl(1'b1, 72'(1) << 70, 1'b0, 1'b0);
      repeat (2) send(rnd());
      drain();

      // Reset with two words in flight; a word offered during reset is refused.
      or_next = 1'b0;
      send(rnd());
      send(rnd());
      rst_next = 1'b1;
      cycle(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0, acc);
      check("rst_no_accept", 128'(acc), 128'(0));
      rst_next = 1'b0;
      or_next  = 1'b1;
      idle();
      check("rst_flush_valid", 128'(bus.out_valid), 128'(0));
      for (int k = 0; k < 5; k++) begin
         idle();
         check("rst_no_stale", 128'(bus.out_valid), 128'(0));
      end

      // Saturation and a narrow-width vector on the second instance.
      n2   = 0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 60 && n2 < 20; cyc++) begin
         @(negedge clk);
         check("dut2_count", 128'(bus2.enc_count), 128'((n2 > 15) ? 4'hF : 4'(n2)));
         bus2.in_valid = 1'b1;
         bus2.in_data  = 32'(n2 + 1);
         #1;
         if (bus2.out_valid && !seen) begin
            seen = 1'b1;
            check("dut2_first_data", 128'(bus2.out_data), 128'(1));
            check("dut2_first_ecc", 128'(bus2.out_ecc), 128'(7'h43));
            check("dut2_first_inj", 128'({bus2.out_injected, bus2.inj_armed}), 128'(0));
            check("dut2_latency", 128'(cyc), 128'(PIPE2));
         end
         if (bus2.in_ready) n2++;
      end
      @(negedge clk);
      bus2.in_valid = 1'b0;
      check("dut2_accepted", 128'(n2), 128'(20));
      check("dut2_saturated", 128'(bus2.enc_count), 128'(4'hF));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
